// File: rtl/weight_sign_buff_reader.sv
// ---------------------------------------------------------------------------
// weight_sign_buff_reader
//
// Read-side controller for the row-parallel weight-sign buffer. One address
// and one read enable are broadcast to every row BRAM, so each returned word
// carries all Ram_Row rows side by side. Returned words land in a small
// credit-managed FIFO that feeds the sparse PE array. The whole buffer
// (word_num words per row) is replayed repeat_num times.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   start        one-cycle request, only looked at while idle
//   word_num     words per row to read (addresses 0..word_num-1)
//   repeat_num   number of full passes over the buffer
//   addrout_row  read address, replicated into every row slice
//   enb_row      read enables, all bits equal
//   datain_row   concatenated BRAM read data, row r in slice r
//   dataout      FIFO head word (zero while empty)
//   out_valid    FIFO holds at least one word
//   out_ready    downstream accepts the head word
//   out_last     head word is the last word of a pass
//   busy         controller is not idle
//   finished     one-cycle completion pulse
//
// Output handshake: a word transfers on every clock edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low,
// dataout and out_last hold their values; out_valid never depends on
// out_ready.
// ---------------------------------------------------------------------------
module weight_sign_buff_reader #(
    parameter int Ram_Row         = 32,
    parameter int Read_Addr_Width = 11,
    parameter int Data_Width      = 64,
    parameter int Rd_Latency      = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [Read_Addr_Width-1:0]           word_num,
    input  logic [7:0]                           repeat_num,
    output logic [Read_Addr_Width*Ram_Row-1:0]   addrout_row,
    output logic [Ram_Row-1:0]                   enb_row,
    input  logic [Data_Width*Ram_Row-1:0]        datain_row,
    output logic [Data_Width*Ram_Row-1:0]        dataout,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 out_last,
    output logic                                 busy,
    output logic                                 finished
);

    localparam int AW    = Read_Addr_Width;
    localparam int WW    = Data_Width * Ram_Row;
    localparam int DEPTH = Rd_Latency + 2;
    localparam int CW    = $clog2(Rd_Latency + 3);
    localparam int PW    = $clog2(DEPTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]            state;
    logic [AW-1:0]         word_num_q;
    logic [7:0]            repeat_num_q;
    logic [AW-1:0]         rd_addr;
    logic [7:0]            pass_cnt;
    logic                  zero_done_q;

    // Issue stage registers driving the BRAM ports.
    logic                  enb_q;
    logic [AW-1:0]         addr_q;
    logic                  last_q;

    // Return-path tags, one stage per cycle of BRAM latency.
    logic [Rd_Latency-1:0] vld_pipe;
    logic [Rd_Latency-1:0] last_pipe;

    // credit = reads in flight + words held in the FIFO.
    logic [CW-1:0]         credit;
    logic [CW-1:0]         credit_after_pop;

    logic [WW-1:0]         mem [DEPTH];
    logic [DEPTH-1:0]      last_mem;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         fifo_count;

    logic                  pop;
    logic                  push;
    logic                  issue;
    logic                  at_row_end;
    logic                  at_final;
    logic                  drain_done;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        pop              = out_valid && out_ready;
        push             = vld_pipe[Rd_Latency-1];
        // A slot freed by this cycle's pop can be reused by this cycle's issue.
        credit_after_pop = credit - CW'(pop);
        issue            = (state == READ) && (credit_after_pop < DEPTH_C);
        at_row_end       = (rd_addr == word_num_q - AW'(1));
        at_final         = at_row_end && (pass_cnt == repeat_num_q - 8'd1);
        // Nothing in flight and nothing buffered: the final pop is done.
        drain_done       = (state == DRAIN) && (credit == '0);
    end

    assign busy        = (state != IDLE);
    assign finished    = drain_done || zero_done_q;
    assign out_valid   = (fifo_count != '0);
    assign dataout     = out_valid ? mem[rd_ptr] : '0;
    assign out_last    = out_valid && last_mem[rd_ptr];
    assign enb_row     = {Ram_Row{enb_q}};
    assign addrout_row = {Ram_Row{addr_q}};

    // Control FSM: word/pass counters and pass bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            word_num_q   <= '0;
            repeat_num_q <= '0;
            rd_addr      <= '0;
            pass_cnt     <= '0;
            zero_done_q  <= 1'b0;
        end else begin
            zero_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (word_num != '0 && repeat_num != '0) begin
                            word_num_q   <= word_num;
                            repeat_num_q <= repeat_num;
                            rd_addr      <= '0;
                            pass_cnt     <= '0;
                            state        <= READ;
                        end else begin
                            // Empty request completes immediately.
                            zero_done_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        if (at_row_end) begin
                            rd_addr  <= '0;
                            pass_cnt <= pass_cnt + 8'd1;
                            if (at_final) begin
                                state <= DRAIN;
                            end
                        end else begin
                            rd_addr <= rd_addr + AW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // BRAM port registers; the address holds between issues.
    always_ff @(posedge clk) begin
        if (rst) begin
            enb_q  <= 1'b0;
            addr_q <= '0;
            last_q <= 1'b0;
        end else begin
            enb_q <= issue;
            if (issue) begin
                addr_q <= rd_addr;
                last_q <= at_row_end;
            end
        end
    end

    // Tags follow the read through the BRAM latency; the last stage marks
    // the cycle in which datain_row carries that read's data.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            vld_pipe[0]  <= enb_q;
            last_pipe[0] <= last_q;
            for (int k = 1; k < Rd_Latency; k++) begin
                vld_pipe[k]  <= vld_pipe[k-1];
                last_pipe[k] <= last_pipe[k-1];
            end
        end
    end

    // Credit and FIFO pointers. The credit rule bounds occupancy by DEPTH,
    // so push never meets a full FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            credit     <= credit + CW'(issue) - CW'(pop);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    // FIFO storage; contents are masked at the outputs while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr]      <= datain_row;
            last_mem[wr_ptr] <= last_pipe[Rd_Latency-1];
        end
    end

endmodule
